// File: rtl/i2c_multi_read_seq_if.sv
// Transaction port and result stream of the multi-channel I2C read sequencer.
// The master side is the sequencer; the slave side is the I2C engine plus the result consumer.
interface i2c_multi_read_seq_if #(
    parameter int CH_W = 1
);
    logic            txn_start;
    logic [6:0]      txn_addr;
    logic            txn_domain;
    logic            txn_done;
    logic            txn_nack;
    logic [7:0]      txn_rd_data;
    logic            out_valid;
    logic            out_ready;
    logic [7:0]      out_data;
    logic [CH_W-1:0] out_chan;
    logic [1:0]      out_err;

    modport master (
        output txn_start, txn_addr, txn_domain,
        input  txn_done, txn_nack, txn_rd_data,
        output out_valid, out_data, out_chan, out_err,
        input  out_ready
    );

    modport slave (
        input  txn_start, txn_addr, txn_domain,
        output txn_done, txn_nack, txn_rd_data,
        input  out_valid, out_data, out_chan, out_err,
        output out_ready
    );
endinterface

// File: rtl/i2c_multi_read_seq.sv
// Reads one byte from each enabled I2C slave channel in ascending order, with
// bounded NACK retry, a per-transaction timeout and a valid/ready result stream.
//
// state | meaning
// IDLE  | waiting for start
// SCAN  | look at mask bit of current channel, skip if disabled
// ISSUE | one-cycle txn_start pulse
// WAIT  | waiting for txn_done or timeout
// EMIT  | result held on the output stream until accepted
// FIN   | one-cycle done pulse
module i2c_multi_read_seq #(
    parameter int NUM_CH    = 2,
    parameter int CH_W      = 1,
    parameter int MAX_RETRY = 2,
    parameter int TIMEOUT   = 4096,
    parameter int TO_W      = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [NUM_CH-1:0]   chan_mask,
    input  logic [7*NUM_CH-1:0] addr_tbl,
    input  logic [NUM_CH-1:0]   dom_tbl,
    output logic                busy,
    output logic                done,
    i2c_multi_read_seq_if.master bus
);
    typedef enum logic [2:0] {IDLE, SCAN, ISSUE, WAIT, EMIT, FIN} state_t;

    localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [2:0]      RETRY_MAX = 3'(MAX_RETRY);

    state_t          state_q, state_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [CH_W-1:0] ch_q, ch_d;
    logic [2:0]      retry_q, retry_d;
    logic [TO_W-1:0] to_q, to_d;
    logic [6:0]      addr_q, addr_d;
    logic            dom_q, dom_d;
    logic [7:0]      od_q, od_d;
    logic [1:0]      oe_q, oe_d;
    logic            busy_q, busy_d, done_q, done_d, txs_q, txs_d, ov_q, ov_d;
    logic [6:0]      addr_arr [NUM_CH];

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) addr_arr[i] = addr_tbl[7*i +: 7];
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        ch_d    = ch_q;
        retry_d = retry_q;
        to_d    = to_q;
        addr_d  = addr_q;
        dom_d   = dom_q;
        od_d    = od_q;
        oe_d    = oe_q;
        case (state_q)
            IDLE: if (start) begin
                mask_d  = chan_mask;
                ch_d    = '0;
                state_d = SCAN;
            end
            SCAN: if (mask_q[ch_q]) begin
                addr_d  = addr_arr[ch_q];
                dom_d   = dom_tbl[ch_q];
                retry_d = '0;
                to_d    = '0;
                state_d = ISSUE;
            end else if (ch_q == CH_LAST) begin
                state_d = FIN;
            end else begin
                ch_d = ch_q + CH_W'(1);
            end
            // The counter runs from the ISSUE cycle so the abort lands TIMEOUT cycles after it.
            ISSUE: begin
                to_d    = to_q + TO_W'(1);
                state_d = WAIT;
            end
            WAIT: if (bus.txn_done) begin
                if (!bus.txn_nack) begin
                    od_d    = bus.txn_rd_data;
                    oe_d    = 2'b00;
                    state_d = EMIT;
                end else if (retry_q < RETRY_MAX) begin
                    retry_d = retry_q + 3'd1;
                    to_d    = '0;
                    state_d = ISSUE;
                end else begin
                    od_d    = 8'h00;
                    oe_d    = 2'b01;
                    state_d = EMIT;
                end
            end else if (to_q == TO_LAST) begin
                od_d    = 8'h00;
                oe_d    = 2'b10;
                state_d = EMIT;
            end else begin
                to_d = to_q + TO_W'(1);
            end
            EMIT: if (bus.out_ready) begin
                if (ch_q == CH_LAST) begin
                    state_d = FIN;
                end else begin
                    ch_d    = ch_q + CH_W'(1);
                    state_d = SCAN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == FIN);
        txs_d  = (state_d == ISSUE);
        ov_d   = (state_d == EMIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mask_q  <= '0;
            ch_q    <= '0;
            retry_q <= '0;
            to_q    <= '0;
            addr_q  <= '0;
            dom_q   <= 1'b0;
            od_q    <= '0;
            oe_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            txs_q   <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            ch_q    <= ch_d;
            retry_q <= retry_d;
            to_q    <= to_d;
            addr_q  <= addr_d;
            dom_q   <= dom_d;
            od_q    <= od_d;
            oe_q    <= oe_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            txs_q   <= txs_d;
            ov_q    <= ov_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign bus.txn_start  = txs_q;
    assign bus.txn_addr   = addr_q;
    assign bus.txn_domain = dom_q;
    assign bus.out_valid  = ov_q;
    assign bus.out_data   = od_q;
    assign bus.out_chan   = ch_q;
    assign bus.out_err    = oe_q;
endmodule

// File: tb/tb_i2c_multi_read_seq.sv
// Directed bench: a 2-channel sequencer (TIMEOUT=16) and a 4-channel one, with
// hand-computed expected results, retries, timeout, back-pressure, reset and empty mask.
module tb_i2c_multi_read_seq;
    logic clk = 1'b0;
    logic rst_n;
    logic start_a, start_b;
    logic [1:0] mask_a;
    logic [3:0] mask_b;
    logic busy_a, done_a, busy_b, done_b;
    int checks = 0;
    int errors = 0;
    int a_starts = 0, b_starts = 0, b_dones = 0;
    int base;

    i2c_multi_read_seq_if #(.CH_W(1)) a ();
    i2c_multi_read_seq_if #(.CH_W(2)) b ();

    i2c_multi_read_seq #(.NUM_CH(2), .CH_W(1), .MAX_RETRY(2), .TIMEOUT(16), .TO_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .chan_mask(mask_a),
        .addr_tbl({7'h20, 7'h10}), .dom_tbl(2'b10),
        .busy(busy_a), .done(done_a), .bus(a)
    );

    i2c_multi_read_seq #(.NUM_CH(4), .CH_W(2), .MAX_RETRY(2), .TIMEOUT(16), .TO_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .chan_mask(mask_b),
        .addr_tbl({7'h43, 7'h42, 7'h41, 7'h40}), .dom_tbl(4'b1000),
        .busy(busy_b), .done(done_b), .bus(b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (a.txn_start === 1'b1) a_starts++;
        if (b.txn_start === 1'b1) b_starts++;
        if (done_b === 1'b1) b_dones++;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic a_wait_start(input string tag);
        int n = 0;
        while (a.txn_start !== 1'b1 && n < 100) begin tick(); n++; end
        chk(tag, 32'(a.txn_start), 32'd1);
    endtask

    task automatic b_wait_start(input string tag);
        int n = 0;
        while (b.txn_start !== 1'b1 && n < 100) begin tick(); n++; end
        chk(tag, 32'(b.txn_start), 32'd1);
    endtask

    task automatic a_respond(input logic nack, input logic [7:0] d);
        a.txn_done = 1'b1; a.txn_nack = nack; a.txn_rd_data = d;
        tick();
        a.txn_done = 1'b0; a.txn_nack = 1'b0; a.txn_rd_data = 8'h00;
    endtask

    task automatic b_respond(input logic [7:0] d);
        b.txn_done = 1'b1; b.txn_nack = 1'b0; b.txn_rd_data = d;
        tick();
        b.txn_done = 1'b0; b.txn_rd_data = 8'h00;
    endtask

    // {valid, data, chan, err}
    function automatic logic [31:0] a_res();
        return 32'({a.out_valid, a.out_data, a.out_chan, a.out_err});
    endfunction

    initial begin
        rst_n = 1'b0;
        start_a = 1'b0; start_b = 1'b0; mask_a = '0; mask_b = '0;
        a.txn_done = 1'b0; a.txn_nack = 1'b0; a.txn_rd_data = '0; a.out_ready = 1'b1;
        b.txn_done = 1'b0; b.txn_nack = 1'b0; b.txn_rd_data = '0; b.out_ready = 1'b1;
        tick(); tick();
        chk("reset_outputs", 32'({busy_a, done_a, a.txn_start, a.txn_addr, a.txn_domain,
                                  a.out_valid, a.out_data, a.out_chan, a.out_err}), 32'd0);
        rst_n = 1'b1;
        tick();

        // Two enabled channels, no NACK
        base = a_starts;
        start_a = 1'b1; mask_a = 2'b11;
        tick();
        start_a = 1'b0;
        chk("busy_after_start", 32'({busy_a, a.txn_start}), 32'b10);
        tick();
        chk("latency_txn_start", 32'(a.txn_start), 32'd1);
        chk("ch0_addr_dom", 32'({a.txn_addr, a.txn_domain}), 32'({7'h10, 1'b0}));
        tick();
        chk("txn_start_one_cycle", 32'(a.txn_start), 32'd0);
        a_respond(1'b0, 8'h12);
        chk("ch0_result", a_res(), 32'({1'b1, 8'h12, 1'b0, 2'b00}));
        tick();
        chk("valid_drops", 32'(a.out_valid), 32'd0);
        tick();
        chk("ch1_issue", 32'({a.txn_start, a.txn_addr, a.txn_domain}), 32'({1'b1, 7'h20, 1'b1}));
        tick();
        a_respond(1'b0, 8'h90);
        chk("ch1_result", a_res(), 32'({1'b1, 8'h90, 1'b1, 2'b00}));
        chk("no_early_done", 32'(done_a), 32'd0);
        tick();
        chk("fin_done_busy", 32'({done_a, busy_a}), 32'b11);
        tick();
        chk("idle_done_busy", 32'({done_a, busy_a}), 32'b00);
        chk("two_txn_pulses", 32'(a_starts - base), 32'd2);

        // NACK twice then ACK
        base = a_starts;
        start_a = 1'b1; mask_a = 2'b01;
        tick();
        start_a = 1'b0;
        a_wait_start("retry_first_issue");
        tick(); a_respond(1'b1, 8'hAB);
        chk("retry1_pulse", 32'(a.txn_start), 32'd1);
        tick(); a_respond(1'b1, 8'hAB);
        chk("retry2_pulse", 32'(a.txn_start), 32'd1);
        tick(); a_respond(1'b0, 8'h34);
        chk("retry_ok_result", a_res(), 32'({1'b1, 8'h34, 1'b0, 2'b00}));
        tick(); tick();
        chk("retry_ok_done", 32'(done_a), 32'd1);
        chk("retry_ok_pulses", 32'(a_starts - base), 32'd3);
        tick();

        // Always NACK
        base = a_starts;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        a_wait_start("nack_first_issue");
        for (int i = 0; i < 3; i++) begin
            tick(); a_respond(1'b1, 8'hAB);
        end
        chk("nack_result", a_res(), 32'({1'b1, 8'h00, 1'b0, 2'b01}));
        chk("nack_pulses", 32'(a_starts - base), 32'd3);
        tick(); tick(); tick();

        // Timeout on ch0, then back-pressure in EMIT
        base = a_starts;
        a.out_ready = 1'b0;
        start_a = 1'b1; mask_a = 2'b11;
        tick();
        start_a = 1'b0;
        tick();
        chk("to_issue", 32'(a.txn_start), 32'd1);
        repeat (15) tick();
        chk("to_not_yet", 32'(a.out_valid), 32'd0);
        tick();
        chk("to_result_16", a_res(), 32'({1'b1, 8'h00, 1'b0, 2'b10}));
        for (int i = 0; i < 20; i++) begin
            chk("stall_stable", 32'({a_res(), a.txn_start}), 32'({1'b1, 8'h00, 1'b0, 2'b10, 1'b0}));
            start_a      = (i == 5);
            mask_a       = (i == 5) ? 2'b00 : 2'b11;
            a.txn_done   = (i == 10);
            a.txn_rd_data = 8'hFF;
            tick();
        end
        start_a = 1'b0; mask_a = 2'b11; a.txn_done = 1'b0; a.txn_rd_data = 8'h00;
        a.out_ready = 1'b1;
        tick();
        chk("stall_release", 32'(a.out_valid), 32'd0);
        tick();
        chk("to_proceeds_ch1", 32'({a.txn_start, a.txn_addr}), 32'({1'b1, 7'h20}));
        tick(); a_respond(1'b0, 8'h5A);
        chk("to_ch1_result", a_res(), 32'({1'b1, 8'h5A, 1'b1, 2'b00}));
        tick();
        chk("to_done", 32'(done_a), 32'd1);
        chk("to_pulses", 32'(a_starts - base), 32'd2);
        tick();

        // Reset while in WAIT
        start_a = 1'b1; mask_a = 2'b01;
        tick();
        start_a = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        #1;
        chk("mid_reset_outputs", 32'({busy_a, done_a, a.txn_start, a.txn_addr, a.txn_domain,
                                      a.out_valid, a.out_data, a.out_chan, a.out_err}), 32'd0);
        tick(); tick();
        chk("mid_reset_no_done", 32'({done_a, busy_a}), 32'd0);
        rst_n = 1'b1;
        tick();

        // Empty mask: done NUM_CH+1 cycles after start
        base = a_starts;
        start_a = 1'b1; mask_a = 2'b00;
        tick();
        start_a = 1'b0;
        chk("empty_c1", 32'({done_a, a.out_valid}), 32'd0);
        tick();
        chk("empty_c2", 32'({done_a, a.out_valid}), 32'd0);
        tick();
        chk("empty_done", 32'({done_a, a.out_valid}), 32'b10);
        tick();
        chk("empty_idle", 32'({done_a, busy_a}), 32'd0);
        chk("empty_no_txn", 32'(a_starts - base), 32'd0);

        // Four channels, mask 1010
        base = b_starts;
        start_b = 1'b1; mask_b = 4'b1010;
        tick();
        start_b = 1'b0;
        b_wait_start("b_ch1_issue");
        chk("b_ch1_addr_dom", 32'({b.txn_addr, b.txn_domain}), 32'({7'h41, 1'b0}));
        tick(); b_respond(8'hC1);
        chk("b_ch1_result", 32'({b.out_valid, b.out_data, b.out_chan, b.out_err}),
            32'({1'b1, 8'hC1, 2'd1, 2'b00}));
        b_wait_start("b_ch3_issue");
        chk("b_ch3_addr_dom", 32'({b.txn_addr, b.txn_domain}), 32'({7'h43, 1'b1}));
        tick(); b_respond(8'hC3);
        chk("b_ch3_result", 32'({b.out_valid, b.out_data, b.out_chan, b.out_err}),
            32'({1'b1, 8'hC3, 2'd3, 2'b00}));
        repeat (6) tick();
        chk("b_pulses", 32'(b_starts - base), 32'd2);
        chk("b_one_done", 32'(b_dones), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
